// File: rtl/vpu_operand_fetch_unit_pkg.sv
// Shared definitions for the vector operand fetch path: slice geometry,
// SRAM address split, FSM state encoding and address helper functions
// that the write-back stage also uses.
package vpu_operand_fetch_unit_pkg;

  localparam int OPERAND_WIDTH       = 16;
  localparam int VLANE_CNT           = 4;
  localparam int ROW_W               = 512;
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 10;

  localparam int ADDR_W       = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
  localparam int SLICE_W      = OPERAND_WIDTH * VLANE_CNT;
  localparam int EXEC_CNT     = ROW_W / SLICE_W;
  localparam int EXEC_CNT_LG2 = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_ISSUE,
    S_DONE
  } fetch_state_e;

  // Bank select lives in the address MSBs.
  function automatic logic [SRAM_BANK_CNT_LG2-1:0] get_bank_id(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: SRAM_BANK_CNT_LG2];
  endfunction

  // Row within the bank lives in the address LSBs.
  function automatic logic [SRAM_BANK_DEPTH_LG2-1:0] get_raddr(input logic [ADDR_W-1:0] addr);
    return addr[SRAM_BANK_DEPTH_LG2-1:0];
  endfunction

endpackage

// File: rtl/vpu_row_unpacker.sv
// Holds one SRAM row and streams it out as EXEC_CNT slices, lowest first,
// over a valid/ready handshake. Slice data and last flag are registered.
module vpu_row_unpacker
  import vpu_operand_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               start,
  input  logic [ROW_W-1:0]   rdata,
  input  logic               op_ready_i,
  output logic               op_valid_o,
  output logic [SLICE_W-1:0] op_data_o,
  output logic               op_last_o,
  output logic               last_xfer_o
);

  logic [ROW_W-1:0]        row_q;
  logic [EXEC_CNT_LG2-1:0] ptr_q;
  logic [EXEC_CNT_LG2-1:0] ptr_nxt;
  logic                    xfer;

  assign xfer        = op_valid_o & op_ready_i;
  assign last_xfer_o = xfer & op_last_o;
  assign ptr_nxt     = ptr_q + 1'b1;

  // Row buffer, slice pointer and the registered slice handshake.
  always_ff @(posedge clk) begin
    // NOTE: the row buffer is plain flops, not a RAM macro, so clearing it
    // in reset costs nothing structural and keeps op_data_o clean after reset.
    if (!rst_n) begin
      row_q      <= '0;
      ptr_q      <= '0;
      op_valid_o <= 1'b0;
      op_data_o  <= '0;
      op_last_o  <= 1'b0;
    end else begin
      if (load) begin
        row_q     <= rdata;
        ptr_q     <= '0;
        op_data_o <= rdata[SLICE_W-1:0];
        op_last_o <= (EXEC_CNT == 1);
      end else if (xfer) begin
        if (op_last_o) begin
          ptr_q     <= '0;
          op_data_o <= '0;
          op_last_o <= 1'b0;
        end else begin
          // NOTE: non-blocking here, so every right-hand side sees the
          // pre-edge ptr_q and ptr_nxt regardless of statement order.
          ptr_q     <= ptr_nxt;
          op_data_o <= row_q[int'(ptr_nxt)*SLICE_W +: SLICE_W];
          op_last_o <= (ptr_nxt == EXEC_CNT_LG2'(EXEC_CNT-1));
        end
      end
      if (start) begin
        op_valid_o <= 1'b1;
      end else if (last_xfer_o) begin
        op_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vpu_operand_fetch_unit.sv
// Vector operand fetch: accepts one request, reads one SRAM row and hands it
// to vpu_row_unpacker for slice streaming to the lanes.
// Optional macro VPU_OPF_STALL_CNT_EN adds stall_cnt_o, a saturating count
// of cycles where a slice was offered but the lanes were not ready.
module vpu_operand_fetch_unit
  import vpu_operand_fetch_unit_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           reset_cmd_i,
  input  logic                           req_valid_i,
  input  logic [ADDR_W-1:0]              req_raddr_i,
  output logic                           req_ready_o,
  output logic                           rd_req_o,
  output logic [SRAM_BANK_CNT_LG2-1:0]   rd_rid_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0] rd_addr_o,
  input  logic                           rd_ack_i,
  input  logic                           rd_rvalid_i,
  input  logic [ROW_W-1:0]               rd_rdata_i,
  output logic                           op_valid_o,
  output logic [SLICE_W-1:0]             op_data_o,
  output logic                           op_last_o,
  input  logic                           op_ready_i,
  output logic                           fetch_done_o
`ifdef VPU_OPF_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cnt_o
`endif
);

  fetch_state_e state_q;
  logic         load;
  logic         last_xfer;
  logic         accept;

  assign accept = (state_q == S_IDLE) & req_ready_o & req_valid_i;

  // Read data is only taken while our request is being acked or awaited;
  // stale rvalid in any other state falls through untouched.
  assign load = ((state_q == S_RD_REQ) & rd_ack_i & rd_rvalid_i) |
                ((state_q == S_RD_WAIT) & rd_rvalid_i);

  // Control FSM with registered request, SRAM and done outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_o  <= 1'b0;
      rd_req_o     <= 1'b0;
      rd_rid_o     <= '0;
      rd_addr_o    <= '0;
      fetch_done_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_ready_o <= 1'b0;
            rd_req_o    <= 1'b1;
            rd_rid_o    <= get_bank_id(req_raddr_i);
            rd_addr_o   <= get_raddr(req_raddr_i);
            state_q     <= S_RD_REQ;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        S_RD_REQ: begin
          if (rd_ack_i) begin
            rd_req_o  <= 1'b0;
            rd_rid_o  <= '0;
            rd_addr_o <= '0;
            state_q   <= rd_rvalid_i ? S_ISSUE : S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_rvalid_i) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (last_xfer) begin
            fetch_done_o <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (reset_cmd_i) begin
            fetch_done_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  vpu_row_unpacker u_unpacker (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .start      (load),
    .rdata      (rd_rdata_i),
    .op_ready_i (op_ready_i),
    .op_valid_o (op_valid_o),
    .op_data_o  (op_data_o),
    .op_last_o  (op_last_o),
    .last_xfer_o(last_xfer)
  );

`ifdef VPU_OPF_STALL_CNT_EN
  // Saturating count of back-pressured slice cycles for the current fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (accept) begin
      stall_cnt_o <= '0;
    end else if (op_valid_o && !op_ready_i && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
